// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide data memory without byte enables.
// Sub-word stores become a read-modify-write across two cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | accept a request; loads and sw finish here, sb/sh read the word
// S_WRITE | write back the merged word captured in wbuf_q at address wa_q
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              fault,
    output logic              fault_sticky,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [0:0] {S_IDLE, S_WRITE} state_t;

    state_t            state;
    logic [31:0]       wbuf_q;
    logic [ADDR_W-1:0] wa_q;

    logic [1:0]        off;
    logic [ADDR_W-1:0] word_addr;
    logic              illegal;
    logic              misaligned;
    logic              accept;
    logic              is_load;
    logic              is_sw;
    logic              is_subword_store;
    logic [31:0]       shifted;
    logic [31:0]       merged;
    logic              unused_addr_bits;

    assign off       = req_addr[1:0];
    assign word_addr = req_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    always_comb begin
        illegal = 1'b0;
        if (req_we)
            illegal = (req_funct3[2] == 1'b1) || (req_funct3[1:0] == 2'd3);
        else
            illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end

    assign misaligned = ((req_funct3[1:0] == 2'd1) && off[0]) ||
                        ((req_funct3[1:0] == 2'd2) && (off != 2'd0));

    assign fault  = req_valid && (state == S_IDLE) && (illegal || misaligned);
    assign accept = req_valid && (state == S_IDLE) && !illegal && !misaligned;

    assign is_load          = accept && !req_we;
    assign is_sw            = accept && req_we && (req_funct3[1:0] == 2'd2);
    assign is_subword_store = accept && req_we && (req_funct3[1:0] != 2'd2);

    assign shifted = mem_rdata >> {off, 3'b000};

    always_comb begin
        load_data = 32'h0;
        if (is_load) begin
            case (req_funct3)
                3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
                3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
                3'd2:    load_data = mem_rdata;
                3'd4:    load_data = {24'h0, shifted[7:0]};
                3'd5:    load_data = {16'h0, shifted[15:0]};
                default: load_data = 32'h0;
            endcase
        end
    end

    // Lane merge for sb/sh; halfword stores are already known to be 2-byte aligned.
    always_comb begin
        merged = mem_rdata;
        if (req_funct3[1:0] == 2'd0)
            merged[{off, 3'b000} +: 8] = req_wdata[7:0];
        else
            merged[{off[1], 4'b0000} +: 16] = req_wdata[15:0];
    end

    always_comb begin
        mem_addr  = word_addr;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 32'h0;
        stall     = 1'b0;
        if (state == S_WRITE) begin
            mem_addr  = wa_q;
            mem_write = 1'b1;
            mem_wdata = wbuf_q;
        end else begin
            mem_read  = is_load || is_subword_store;
            mem_write = is_sw;
            mem_wdata = is_sw ? req_wdata : 32'h0;
            stall     = is_subword_store;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wbuf_q       <= 32'h0;
            wa_q         <= '0;
            fault_sticky <= 1'b0;
        end else begin
            if (fault)
                fault_sticky <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (is_subword_store) begin
                        wbuf_q <= merged;
                        wa_q   <= word_addr;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues the expected outputs of
// each request cycle and a negedge monitor compares them against the DUT.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] load_data;
    logic        stall;
    logic        fault;
    logic        fault_sticky;
    logic [7:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       nm;
        logic [76:0] v;   // {stall, rd, wr, fault, sticky, addr[7:0], wdata[31:0], ldata[31:0]}
    } exp_t;

    exp_t q[$];

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
    localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .load_data(load_data), .stall(stall), .fault(fault), .fault_sticky(fault_sticky),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_read ? mem[mem_addr] : 32'hBAD0BAD0;

    always @(posedge clk)
        if (mem_write) mem[mem_addr] <= mem_wdata;

    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    always @(negedge clk) begin
        exp_t        e;
        logic [76:0] act;
        if (q.size() != 0) begin
            e   = q.pop_front();
            act = {stall, mem_read, mem_write, fault, fault_sticky, mem_addr, mem_wdata, load_data};
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s: got ctl=%b addr=%h wdata=%h ldata=%h, expected ctl=%b addr=%h wdata=%h ldata=%h",
                         e.nm, act[76:72], act[71:64], act[63:32], act[31:0],
                         e.v[76:72], e.v[71:64], e.v[63:32], e.v[31:0]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, a, e);
        end
    endtask

    // ctl = {stall, mem_read, mem_write, fault, fault_sticky}
    task automatic drive(input string nm, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] ctl,
                         input logic [7:0] ea, input logic [31:0] ewd, input logic [31:0] eld);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        e.nm = nm;
        e.v  = {ctl, ea, ewd, eld};
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, outputs idle while reset held
        drive("reset_idle", 0, 0, 3'd0, 32'h0, 32'h0, 5'b00000, 8'h00, 32'h0, 32'h0);
        @(negedge clk);
        #1 reset = 1'b0;

        // 1: sw then lw
        drive("sw_10", 1, 1, SW, 32'h10, 32'hDEADBEEF, 5'b00100, 8'h04, 32'hDEADBEEF, 32'h0);
        drive("lw_10", 1, 0, LW, 32'h10, 32'h0, 5'b01000, 8'h04, 32'h0, 32'hDEADBEEF);

        // 2: sb read-modify-write, request held through the stall
        drive("sb_12_rd", 1, 1, SB, 32'h12, 32'h55, 5'b11000, 8'h04, 32'h0, 32'h0);
        drive("sb_12_wr", 1, 1, SB, 32'h12, 32'h55, 5'b00100, 8'h04, 32'hDE55BEEF, 32'h0);
        drive("lw_after_sb", 1, 0, LW, 32'h10, 32'h0, 5'b01000, 8'h04, 32'h0, 32'hDE55BEEF);

        // 3: extension variants
        drive("lb_13",  1, 0, LB,  32'h13, 32'h0, 5'b01000, 8'h04, 32'h0, 32'hFFFFFFDE);
        drive("lbu_13", 1, 0, LBU, 32'h13, 32'h0, 5'b01000, 8'h04, 32'h0, 32'h000000DE);
        drive("lh_10",  1, 0, LH,  32'h10, 32'h0, 5'b01000, 8'h04, 32'h0, 32'hFFFFBEEF);
        drive("lhu_12", 1, 0, LHU, 32'h12, 32'h0, 5'b01000, 8'h04, 32'h0, 32'h0000DE55);
        drive("lb_11",  1, 0, LB,  32'h11, 32'h0, 5'b01000, 8'h04, 32'h0, 32'hFFFFFFBE);
        drive("lw_hi_addr_ignored", 1, 0, LW, 32'hF0000010, 32'h0, 5'b01000, 8'h04, 32'h0, 32'hDE55BEEF);

        // 4: faults and sticky flag
        drive("sh_11_fault", 1, 1, SH, 32'h11, 32'h1234, 5'b00010, 8'h04, 32'h0, 32'h0);
        drive("sticky_set",  0, 0, 3'd0, 32'h0, 32'h0, 5'b00001, 8'h00, 32'h0, 32'h0);
        drive("ld_f3_3_fault", 1, 0, 3'd3, 32'h10, 32'h0, 5'b00011, 8'h04, 32'h0, 32'h0);
        drive("st_f3_4_fault", 1, 1, 3'd4, 32'h10, 32'h0, 5'b00011, 8'h04, 32'h0, 32'h0);
        drive("sw_12_misalign", 1, 1, SW, 32'h12, 32'h1, 5'b00011, 8'h04, 32'h0, 32'h0);
        drive("lw_13_misalign", 1, 0, LW, 32'h13, 32'h0, 5'b00011, 8'h04, 32'h0, 32'h0);
        drive("sticky_held", 0, 0, 3'd0, 32'h0, 32'h0, 5'b00001, 8'h00, 32'h0, 32'h0);

        // 5: reset during WRITE aborts the store
        drive("sh_22_rd", 1, 1, SH, 32'h22, 32'h1234, 5'b11001, 8'h08, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("write_phase_we", {31'h0, mem_write}, 32'h1);
        chk("write_phase_wdata", mem_wdata, 32'h12340000);
        #2;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_sticky", {31'h0, fault_sticky}, 32'h0);
        @(posedge clk);
        #1;
        chk("word8_untouched", mem[8], 32'h0);
        reset = 1'b0;
        drive("after_rst_idle", 0, 0, 3'd0, 32'h0, 32'h0, 5'b00000, 8'h00, 32'h0, 32'h0);
        drive("lw_word8", 1, 0, LW, 32'h20, 32'h0, 5'b01000, 8'h08, 32'h0, 32'h0);

        // 6: back-to-back sh, stall 1,0,1,0
        drive("sh_00_rd", 1, 1, SH, 32'h00, 32'hAAAA, 5'b11000, 8'h00, 32'h0, 32'h0);
        drive("sh_00_wr", 1, 1, SH, 32'h00, 32'hAAAA, 5'b00100, 8'h00, 32'h0000AAAA, 32'h0);
        drive("sh_02_rd", 1, 1, SH, 32'h02, 32'hBBBB, 5'b11000, 8'h00, 32'h0, 32'h0);
        drive("sh_02_wr", 1, 1, SH, 32'h02, 32'hBBBB, 5'b00100, 8'h00, 32'hBBBBAAAA, 32'h0);
        drive("lw_00", 1, 0, LW, 32'h00, 32'h0, 5'b01000, 8'h00, 32'h0, 32'hBBBBAAAA);
        drive("lh_02", 1, 0, LH, 32'h02, 32'h0, 5'b01000, 8'h00, 32'h0, 32'hFFFFBBBB);
        drive("idle_end", 0, 0, 3'd0, 32'h0, 32'h0, 5'b00000, 8'h00, 32'h0, 32'h0);

        @(negedge clk);
        #1;
        chk("word0_final", mem[0], 32'hBBBBAAAA);
        chk("scoreboard_drained", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
